// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: FSM states, column drive patterns and key map for the keypad scanner.
package keypad_scanner_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  // Indexed by {col, row}: col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
  localparam logic [15:0][3:0] KEY_MAP = 64'hDCBA_E963_F852_0741;
  function automatic logic [1:0] low_row(input logic [3:0] r);
    return !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchronizer for the idle-high keypad rows.
module sync_2ff (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] s1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, s1} <= '1;
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with debounce and a valid/ready key handshake.
// Define KEYPAD_ACCUM_EN to shift each accepted key into the 32-bit value accumulator.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_held,
  output logic        key_ovf,
  output logic [31:0] value
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  state_t state, state_nx;
  logic [3:0] row_s, pat, pat_nx, key;
  logic [1:0] col_idx, col_idx_nx;
  logic [DW-1:0] dwell;
  logic [CW-1:0] dcnt, dcnt_nx;
  logic tick, vld_eff, load, ovf_set;
  sync_2ff u_sync (.clk(clk), .reset_n(reset_n), .d(row), .q(row_s));
  assign tick     = dwell == DW'(SCAN_DIV - 1);
  assign col      = COL_DRIVE[col_idx];
  assign key      = KEY_MAP[{col_idx, low_row(pat)}];
  // A handshake in the same cycle frees the slot before the new key is offered.
  assign vld_eff  = key_valid & ~key_ready;
  assign load     = state == PRESSED && !vld_eff;
  assign ovf_set  = state == PRESSED && vld_eff;
  assign key_held = state == RELEASE;
  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    dcnt_nx    = dcnt;
    pat_nx     = pat;
    if (state == PRESSED) begin
      state_nx = RELEASE;
      dcnt_nx  = '0;
    end else if (tick)
      case (state)
        SCAN:
          if (row_s == 4'hF) col_idx_nx = col_idx + 2'd1;
          else begin
            state_nx = DEBOUNCE;
            pat_nx   = row_s;
            dcnt_nx  = '0;
          end
        DEBOUNCE:
          if (row_s != pat) begin
            state_nx   = SCAN;
            col_idx_nx = col_idx + 2'd1;
          end else if (dcnt == CW'(DEBOUNCE_CNT - 1)) state_nx = PRESSED;
          else dcnt_nx = dcnt + 1'b1;
        RELEASE:
          if (row_s != 4'hF) dcnt_nx = '0;
          else if (dcnt == CW'(DEBOUNCE_CNT - 1)) begin
            state_nx   = SCAN;
            col_idx_nx = col_idx + 2'd1;
            dcnt_nx    = '0;
          end else dcnt_nx = dcnt + 1'b1;
        default: ;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= SCAN;
      col_idx   <= '0;
      dwell     <= '0;
      dcnt      <= '0;
      pat       <= '1;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_ovf   <= 1'b0;
    end else begin
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      dwell     <= tick ? '0 : dwell + 1'b1;
      dcnt      <= dcnt_nx;
      pat       <= pat_nx;
      key_valid <= load | vld_eff;
      if (load) key_code <= key;
      if (ovf_set) key_ovf <= 1'b1;
    end
`ifdef KEYPAD_ACCUM_EN
  logic [31:0] acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc <= '0;
    else if (state == PRESSED) acc <= {acc[27:0], key};
  assign value = acc;
`else
  assign value = '0;
`endif
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each column is driven before its rows are sampled.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, consecutive identical row samples needed to accept a press or release.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at a time.
REQ-007 SHALL have port key_code  output  4  hex value of the accepted key.
REQ-008 SHALL have port key_valid  output  1  key_code holds an unconsumed key.
REQ-009 SHALL have port key_ready  input  1  consumer accepts key_code when high with key_valid.
REQ-010 SHALL have port key_held  output  1  accepted key still physically pressed.
REQ-011 SHALL have port key_ovf  output  1  sticky, a press was accepted while key_valid was high.
REQ-012 SHALL have port value  output  32  hex-digit accumulator for the 7-segment display path.

Function
REQ-013 SHALL pass row through a 2-flop synchronizer before any use.
REQ-014 SHALL use a dwell counter of width clog2(SCAN_DIV) that samples synchronized rows on the cycle it reaches SCAN_DIV-1, then wraps to 0.
REQ-015 SHALL use FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN: SHALL advance col 1110->1101->1011->0111->1110 after each sample with rows==1111; on any low row, SHALL latch the row pattern and go to DEBOUNCE, keeping col.
REQ-017 DEBOUNCE: SHALL count samples equal to the latched pattern; on reaching DEBOUNCE_CNT, go PRESSED; on mismatch, return to SCAN and advance the column.
REQ-018 SHALL resolve multiple low rows to the lowest-index row; keys in other columns SHALL be ignored until RELEASE completes.
REQ-019 SHALL map keys as (col0: rows0-3 = 1,4,7,0), (col1: 2,5,8,F), (col2: 3,6,9,E), (col3: A,B,C,D).
REQ-020 PRESSED (one cycle): SHALL load key_code and set key_valid if key_valid is low; otherwise keep the old key_code and set key_ovf; then go RELEASE.
REQ-021 SHALL hold key_valid and key_code stable until the cycle key_valid&key_ready is high; key_valid SHALL clear on the next edge.
REQ-022 SHALL NOT let key_valid fall while key_ready is low.
REQ-023 RELEASE: SHALL hold col, assert key_held, and require DEBOUNCE_CNT consecutive 1111 samples; any low sample SHALL restart the count; on completion, go SCAN and advance the column.
REQ-024 key_ovf SHALL clear only on reset.
REQ-025 Same-cycle handshake and new accept: SHALL treat the key as consumed first, then load the new key with key_valid high and no overflow.

Reset
REQ-026 On reset_n low: state=SCAN, col=1110, key_code=0, key_valid=0, key_held=0, key_ovf=0, value=0, all counters 0, synchronizer=1111.
REQ-027 Reset mid-debounce or mid-handshake SHALL discard the pending key without emitting it.

Configuration
REQ-028 With KEYPAD_ACCUM_EN defined: each accepted key SHALL make value = {value[27:0], key_code} in the PRESSED cycle, including when overflowing.
REQ-029 Without KEYPAD_ACCUM_EN: value SHALL be constant 0 and no accumulator register SHALL exist.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the column one-hot constants and the 16-entry key map.
REQ-031 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, 4 bits wide.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-032 Press key '5' (col1,row1) held 40 cycles, key_ready=1 -> one key_valid pulse with key_code=5, key_held high until 3 clean 1111 samples after release.
REQ-033 Bounce row0 low for 1 sample then high on col0 -> no key_valid, scanning resumes at col1.
REQ-034 key_ready=0, press '1' then 'A' -> key_code stays 1, key_ovf=1, value=0x1A with the macro and 0 without it.
REQ-035 Hold '7' and '8' together -> only the key in the first-scanned column (7) is accepted; '8' is accepted only after a full release.
REQ-036 Assert reset_n low during DEBOUNCE -> all outputs at reset values next cycle, col=1110, no key emitted.
